scc_pgen: RTL
=============

SCC_PGEN -- requirements
Module: scc_pgen

Interface
REQ-001 Parameter N_CH, default 8, number of event-triggered pulse channels, legal range 1..15.
REQ-002 Parameter EV_W, default 8, event code width.
REQ-003 Parameter DLY_W, default 16, delay counter width.
REQ-004 Parameter WID_W, default 8, pulse width counter width.
REQ-005 Port clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-006 Port aresetn  input  1  reset, synchronous, active-low.
REQ-007 Port mmr  axi4_lite_if.s  -  register slave; 8-bit device address, 32-bit data.
REQ-008 Port ev  input  EV_W  event code from the EVR, valid for one clk per event; 0 means no event.
REQ-009 Port pulse  output  N_CH  per-channel pulse outputs, registered.
REQ-010 Port busy  output  N_CH  per-channel high while the channel is in DELAY or PULSE.

Function
REQ-011 Register map: 0x00 GCR (bit0 global enable); 0x04 OVR (sticky overrun flags, W1C); 0x10+0x10*k channel k: +0x0 EV, +0x4 DLY, +0x8 WID, +0xC CCR (bit0 enable, bit1 polarity invert, bit2 retrigger).
REQ-012 Reads of unmapped addresses, or of channels >= N_CH, SHALL return 0; writes to them SHALL be ignored; RRESP and BRESP SHALL always be OKAY.
REQ-013 AXI: AW and W SHALL be accepted independently (ready pulsed 1 cycle, one outstanding each); BVALID SHALL assert the cycle after both are held and clear on BREADY; the register update SHALL occur on the B handshake.
REQ-014 AXI read: ARREADY pulsed 1 cycle on acceptance; RVALID SHALL assert the next cycle with RDATA stable until RREADY.
REQ-015 Channel k triggers when GCR.enable=1, CCR.enable=1, EV!=0 and ev==EV; EV=0 never triggers.
REQ-016 Per-channel FSM: IDLE -> DELAY on trigger; DELAY -> PULSE when delay count expires; PULSE -> IDLE when width count expires.
REQ-017 DLY and WID SHALL be latched into shadow counters at trigger; register writes during DELAY/PULSE SHALL affect only subsequent triggers.
REQ-018 Timing: trigger sampled at cycle T -> pulse active from T+1+DLY for max(WID,1) cycles; WID=0 is treated as 1.
REQ-019 DLY=0 SHALL skip DELAY (IDLE -> PULSE directly).
REQ-020 Trigger while busy with CCR.retrigger=1: SHALL restart from DELAY (or PULSE if DLY=0) with fresh shadow values; OVR[k] unchanged.
REQ-021 Trigger while busy with CCR.retrigger=0: SHALL be ignored and set OVR[k]=1.
REQ-022 Simultaneous OVR[k] set and W1C clear of bit k: set SHALL win.
REQ-023 pulse[k] SHALL equal active XOR CCR.polarity, with active=1 only in PULSE.
REQ-024 Clearing GCR.enable or CCR.enable SHALL force affected channels to IDLE on the next cycle.
REQ-025 Multiple channels with the same EV SHALL all trigger in the same cycle.
REQ-026 Counters SHALL count down without wrap; DLY=2^DLY_W-1 SHALL yield exactly that delay.

Reset
REQ-027 While aresetn=0: all registers 0, all channels IDLE, busy=0, pulse=0, AXI valid/ready outputs 0.
REQ-028 First cycle after reset release: pulse[k]=CCR.polarity=0, and AXI accepts transactions.

Verification
REQ-029 Ch0 EV=0x21, DLY=5, WID=3, enabled; ev=0x21 at T -> pulse[0]=1 at T+6..T+8, busy[0]=1 T+1..T+8.
REQ-030 Ch1 DLY=0, WID=0, polarity=1; trigger at T -> pulse[1]=0 only at T+1, 1 elsewhere.
REQ-031 Ch2 DLY=10, WID=2, retrigger=0; triggers at T and T+4 -> single pulse at T+11..T+12, OVR=0x4; write 0x4 to OVR -> OVR=0.
REQ-032 Same with retrigger=1 -> single pulse at T+15..T+16, OVR=0.
REQ-033 Write DLY=20 to ch0 during its DELAY -> current pulse keeps old delay; next trigger uses 20.
REQ-034 Read 0x10+0x10*N_CH -> 0, RRESP=OKAY; ev=0 with channel EV=0 -> no trigger; assert aresetn mid-PULSE -> pulse=0 next cycle.

Source files
------------

// File: rtl/scc_pgen_if.sv
// AXI4-Lite register bus: 8-bit byte address, 32-bit data, no protection signals.
interface axi4_lite_if;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/scc_pgen.sv
// Event-triggered pulse generator: per-channel delay/width pulses fired by matching
// EVR event codes, configured through an AXI4-Lite register slave.
module scc_pgen #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned EV_W  = 8,
    parameter int unsigned DLY_W = 16,
    parameter int unsigned WID_W = 8
) (
    input  logic            clk,
    input  logic            aresetn,
    axi4_lite_if.s          mmr,
    input  logic [EV_W-1:0] ev,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] busy
);

    typedef enum logic [1:0] {StIdle, StDelay, StPulse} ch_st_e;

    // AXI front end
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic        aw_held_q, w_held_q;
    logic [7:0]  aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] rdata_q, rd_val;
    logic        aw_hs, w_hs, b_hs, ar_hs;

    // Registers
    logic             gcr_q, gcr_d;
    logic [N_CH-1:0]  ovr_q, ovr_d, ovr_set, ovr_clr;
    logic [EV_W-1:0]  ch_ev_q  [N_CH];
    logic [EV_W-1:0]  ch_ev_d  [N_CH];
    logic [DLY_W-1:0] ch_dly_q [N_CH];
    logic [DLY_W-1:0] ch_dly_d [N_CH];
    logic [WID_W-1:0] ch_wid_q [N_CH];
    logic [WID_W-1:0] ch_wid_d [N_CH];
    logic [2:0]       ch_ccr_q [N_CH];
    logic [2:0]       ch_ccr_d [N_CH];

    // Channel state and shadow counters
    ch_st_e           st_q   [N_CH];
    ch_st_e           st_d   [N_CH];
    logic [DLY_W-1:0] dcnt_q [N_CH];
    logic [DLY_W-1:0] dcnt_d [N_CH];
    logic [WID_W-1:0] wcnt_q [N_CH];
    logic [WID_W-1:0] wcnt_d [N_CH];
    logic [N_CH-1:0]  pulse_q, pulse_d, trig;

    logic [31:0] wr_cur, wmask, wval;
    logic        unused_wbits;

    function automatic logic [31:0] reg_read(input logic [7:0] a);
        logic [31:0] r;
        r = '0;
        if (a[1:0] == 2'b00) begin
            if (a[7:4] == 4'h0) begin
                if (a[3:2] == 2'd0)      r = {31'b0, gcr_q};
                else if (a[3:2] == 2'd1) r = 32'(ovr_q);
            end
            for (int k = 0; k < N_CH; k++) begin
                if (a[7:4] == 4'(k + 1)) begin
                    case (a[3:2])
                        2'd0:    r = 32'(ch_ev_q[k]);
                        2'd1:    r = 32'(ch_dly_q[k]);
                        2'd2:    r = 32'(ch_wid_q[k]);
                        default: r = {29'b0, ch_ccr_q[k]};
                    endcase
                end
            end
        end
        return r;
    endfunction

    assign aw_hs = mmr.awvalid && awready_q;
    assign w_hs  = mmr.wvalid && wready_q;
    assign b_hs  = bvalid_q && mmr.bready;
    assign ar_hs = mmr.arvalid && arready_q;

    assign mmr.awready = awready_q;
    assign mmr.wready  = wready_q;
    assign mmr.bvalid  = bvalid_q;
    assign mmr.bresp   = 2'b00;
    assign mmr.arready = arready_q;
    assign mmr.rvalid  = rvalid_q;
    assign mmr.rdata   = rdata_q;
    assign mmr.rresp   = 2'b00;

    assign rd_val = reg_read(mmr.araddr);
    assign pulse  = pulse_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rdata_q   <= '0;
        end else begin
            awready_q <= mmr.awvalid && !aw_held_q && !awready_q;
            wready_q  <= mmr.wvalid && !w_held_q && !wready_q;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= mmr.awaddr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= mmr.wdata;
                w_strb_q <= mmr.wstrb;
            end
            if (b_hs) begin
                bvalid_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else if (aw_held_q && w_held_q) begin
                bvalid_q <= 1'b1;
            end
            arready_q <= mmr.arvalid && !arready_q && !rvalid_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (rvalid_q && mmr.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register writes commit on the B handshake; untouched byte lanes keep their value.
    always_comb begin
        wr_cur = reg_read(aw_addr_q);
        for (int b = 0; b < 4; b++) wmask[8*b+:8] = {8{w_strb_q[b]}};
        wval    = (w_data_q & wmask) | (wr_cur & ~wmask);
        gcr_d   = gcr_q;
        ovr_clr = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_ev_d[k]  = ch_ev_q[k];
            ch_dly_d[k] = ch_dly_q[k];
            ch_wid_d[k] = ch_wid_q[k];
            ch_ccr_d[k] = ch_ccr_q[k];
        end
        if (b_hs && aw_addr_q[1:0] == 2'b00) begin
            if (aw_addr_q[7:4] == 4'h0) begin
                if (aw_addr_q[3:2] == 2'd0)      gcr_d = wval[0];
                else if (aw_addr_q[3:2] == 2'd1) ovr_clr = w_data_q[N_CH-1:0] & wmask[N_CH-1:0];
            end
            for (int k = 0; k < N_CH; k++) begin
                if (aw_addr_q[7:4] == 4'(k + 1)) begin
                    case (aw_addr_q[3:2])
                        2'd0:    ch_ev_d[k]  = wval[EV_W-1:0];
                        2'd1:    ch_dly_d[k] = wval[DLY_W-1:0];
                        2'd2:    ch_wid_d[k] = wval[WID_W-1:0];
                        default: ch_ccr_d[k] = wval[2:0];
                    endcase
                end
            end
        end
    end

    assign unused_wbits = ^{wval, w_data_q, wmask};

    always_comb begin
        trig    = '0;
        ovr_set = '0;
        pulse_d = '0;
        busy    = '0;
        for (int k = 0; k < N_CH; k++) begin
            st_d[k]   = st_q[k];
            dcnt_d[k] = dcnt_q[k];
            wcnt_d[k] = wcnt_q[k];
            trig[k]   = gcr_q && ch_ccr_q[k][0] && (ch_ev_q[k] != '0) && (ev == ch_ev_q[k]);
            if (!gcr_q || !ch_ccr_q[k][0]) begin
                st_d[k] = StIdle;
            end else if (trig[k] && (st_q[k] == StIdle || ch_ccr_q[k][2])) begin
                // Width is loaded now and held untouched through DELAY.
                wcnt_d[k] = (ch_wid_q[k] == '0) ? WID_W'(1) : ch_wid_q[k];
                dcnt_d[k] = ch_dly_q[k];
                st_d[k]   = (ch_dly_q[k] == '0) ? StPulse : StDelay;
            end else begin
                ovr_set[k] = trig[k];
                case (st_q[k])
                    StDelay: begin
                        if (dcnt_q[k] <= DLY_W'(1)) st_d[k] = StPulse;
                        else dcnt_d[k] = dcnt_q[k] - DLY_W'(1);
                    end
                    StPulse: begin
                        if (wcnt_q[k] <= WID_W'(1)) st_d[k] = StIdle;
                        else wcnt_d[k] = wcnt_q[k] - WID_W'(1);
                    end
                    default: ;
                endcase
            end
            pulse_d[k] = (st_d[k] == StPulse) ^ ch_ccr_d[k][1];
            busy[k]    = (st_q[k] != StIdle);
        end
        // A new overrun wins over a simultaneous W1C.
        ovr_d = (ovr_q & ~ovr_clr) | ovr_set;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            gcr_q   <= 1'b0;
            ovr_q   <= '0;
            pulse_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                ch_ev_q[k]  <= '0;
                ch_dly_q[k] <= '0;
                ch_wid_q[k] <= '0;
                ch_ccr_q[k] <= '0;
                st_q[k]     <= StIdle;
                dcnt_q[k]   <= '0;
                wcnt_q[k]   <= '0;
            end
        end else begin
            gcr_q   <= gcr_d;
            ovr_q   <= ovr_d;
            pulse_q <= pulse_d;
            for (int k = 0; k < N_CH; k++) begin
                ch_ev_q[k]  <= ch_ev_d[k];
                ch_dly_q[k] <= ch_dly_d[k];
                ch_wid_q[k] <= ch_wid_d[k];
                ch_ccr_q[k] <= ch_ccr_d[k];
                st_q[k]     <= st_d[k];
                dcnt_q[k]   <= dcnt_d[k];
                wcnt_q[k]   <= wcnt_d[k];
            end
        end
    end

endmodule
